// File: rtl/tmpreg_ctrl.sv
// Temp-register (reorder) controller: allocates tags at dispatch, marks results on writeback,
// and retires completed entries in order from the head of an externally stored 32-entry file.
module tmpreg_ctrl #(
  parameter int unsigned ENTRIES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,

  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [4:0]  disp_rd,
  input  logic [31:0] disp_pc,
  input  logic [1:0]  disp_type,
  output logic [4:0]  disp_tag,

  input  logic        cdb_valid,
  input  logic [4:0]  cdb_tag,
  input  logic [31:0] cdb_data,

  output logic        commit_valid,
  input  logic        commit_ready,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_pc,
  output logic [1:0]  commit_type,
  output logic [31:0] commit_data,

  input  logic [4:0]  lookup_tag,
  output logic [72:0] lookup_data,
  output logic [5:0]  count,

  output logic [72:0] rf_data_in,
  output logic [4:0]  rf_waddr,
  output logic        rf_new_entry,
  output logic        rf_update_entry,
  output logic [4:0]  rf_rd_addr1,
  input  logic [72:0] rf_data_out1,
  output logic [4:0]  rf_rd_addr2,
  input  logic [72:0] rf_data_out2
);

  localparam logic [5:0] FullCount = 6'(ENTRIES);

  logic [4:0] r_head;
  logic [4:0] r_tail;
  logic [5:0] r_count;

  logic [4:0] w_head_nxt;
  logic [4:0] w_tail_nxt;
  logic [5:0] w_count_nxt;

  logic       w_full;
  logic       w_empty;
  logic       w_disp_acc;
  logic [4:0] w_wb_offset;
  logic       w_wb_in_window;
  logic       w_wb;
  logic       w_commit;

  assign w_full  = (r_count == FullCount);
  assign w_empty = (r_count == 6'd0);

  // Writeback owns the single write port, so dispatch stalls whenever the CDB is active.
  assign disp_ready = !w_full && !cdb_valid && !flush;
  assign w_disp_acc = disp_valid && disp_ready;
  assign disp_tag   = r_tail;

  // Tag is live iff its distance from head (mod 32) is below the occupancy.
  assign w_wb_offset    = cdb_tag - r_head;
  assign w_wb_in_window = ({1'b0, w_wb_offset} < r_count);
  assign w_wb           = cdb_valid && !flush && w_wb_in_window;

  assign rf_rd_addr1  = r_head;
  assign commit_valid = !w_empty && rf_data_out1[0] && rf_data_out1[1] && !flush;
  assign commit_rd    = rf_data_out1[72:68];
  assign commit_pc    = rf_data_out1[67:36];
  assign commit_type  = rf_data_out1[35:34];
  assign commit_data  = rf_data_out1[33:2];
  assign w_commit     = commit_valid && commit_ready;

  assign rf_rd_addr2 = lookup_tag;
  assign lookup_data = rf_data_out2;
  assign count       = r_count;

  always_comb begin
    rf_new_entry    = 1'b0;
    rf_update_entry = 1'b0;
    rf_waddr        = 5'd0;
    rf_data_in      = 73'd0;
    if (w_wb) begin
      rf_update_entry  = 1'b1;
      rf_waddr         = cdb_tag;
      rf_data_in[33:2] = cdb_data;
      rf_data_in[1]    = 1'b1;
    end else if (w_disp_acc) begin
      rf_new_entry = 1'b1;
      rf_waddr     = r_tail;
      rf_data_in   = {disp_rd, disp_pc, disp_type, 32'h0, 1'b0, 1'b1};
    end
  end

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (flush) begin
      w_head_nxt  = 5'd0;
      w_tail_nxt  = 5'd0;
      w_count_nxt = 6'd0;
    end else begin
      if (w_commit) begin
        w_head_nxt = r_head + 5'd1;
      end
      if (w_disp_acc) begin
        w_tail_nxt = r_tail + 5'd1;
      end
      unique case ({w_disp_acc, w_commit})
        2'b10:   w_count_nxt = r_count + 6'd1;
        2'b01:   w_count_nxt = r_count - 6'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= 5'd0;
      r_tail  <= 5'd0;
      r_count <= 6'd0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_tmpreg_ctrl.sv
// Bench for tmpreg_ctrl: directed scenarios plus randomized traffic against a queue-based model,
// with a 32x73 temp register file model attached to the rf_* ports.
module tb_tmpreg_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_rd;
  logic [31:0] disp_pc;
  logic [1:0]  disp_type;
  logic [4:0]  disp_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_valid;
  logic        commit_ready;
  logic [4:0]  commit_rd;
  logic [31:0] commit_pc;
  logic [1:0]  commit_type;
  logic [31:0] commit_data;
  logic [4:0]  lookup_tag;
  logic [72:0] lookup_data;
  logic [5:0]  count;
  logic [72:0] rf_data_in;
  logic [4:0]  rf_waddr;
  logic        rf_new_entry;
  logic        rf_update_entry;
  logic [4:0]  rf_rd_addr1;
  logic [72:0] rf_data_out1;
  logic [4:0]  rf_rd_addr2;
  logic [72:0] rf_data_out2;

  int checks = 0;
  int errors = 0;

  tmpreg_ctrl #(.ENTRIES(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_type(disp_type), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rd(commit_rd),
    .commit_pc(commit_pc), .commit_type(commit_type), .commit_data(commit_data),
    .lookup_tag(lookup_tag), .lookup_data(lookup_data), .count(count),
    .rf_data_in(rf_data_in), .rf_waddr(rf_waddr), .rf_new_entry(rf_new_entry),
    .rf_update_entry(rf_update_entry), .rf_rd_addr1(rf_rd_addr1),
    .rf_data_out1(rf_data_out1), .rf_rd_addr2(rf_rd_addr2), .rf_data_out2(rf_data_out2)
  );

  always #5 clock = ~clock;

  // Temp register file: full write on new entry, spec_data/spec_valid only on update.
  logic [72:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
  always @(posedge clock) begin
    if (rf_new_entry) rf_mem[rf_waddr] <= rf_data_in;
    else if (rf_update_entry) rf_mem[rf_waddr][33:1] <= rf_data_in[33:1];
  end
  assign rf_data_out1 = rf_mem[rf_rd_addr1];
  assign rf_data_out2 = rf_mem[rf_rd_addr2];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  typ;
    logic [31:0] data;
    logic        sv;
  } ent_t;

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; disp_rd = 0; disp_pc = 0; disp_type = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; commit_ready = 0; lookup_tag = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic dispatch_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      idle_inputs();
      disp_valid = 1; disp_rd = 5'(i); disp_pc = $urandom; disp_type = 2'(i);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_reset();
    dispatch_n(2);
    #2 reset = 1;
    #1;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (disp_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", disp_tag); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", disp_ready); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b exp 0", commit_valid); end
    checks++;
    if ({rf_new_entry, rf_update_entry, rf_waddr} !== 7'd0) begin
      errors++;
      $display("FAIL reset_strobes got %b/%b/%0d exp 0/0/0", rf_new_entry, rf_update_entry, rf_waddr);
    end
    @(negedge clock);
    reset = 0;
    disp_valid = 1; disp_rd = 5'd9;
    #1;
    checks++; if (disp_tag !== 5'd0) begin errors++; $display("FAIL reset_first_tag got %0d exp 0", disp_tag); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_dispatch();
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pc = $urandom;
      disp_valid = 1; disp_rd = 5'(5 + i); disp_pc = pc; disp_type = 2'(i);
      #1;
      checks++;
      if (disp_tag !== 5'(i) || rf_new_entry !== 1'b1 || rf_update_entry !== 1'b0 || rf_waddr !== 5'(i)) begin
        errors++;
        $display("FAIL disp_%0d got tag %0d new %b upd %b waddr %0d exp %0d 1 0 %0d",
                 i, disp_tag, rf_new_entry, rf_update_entry, rf_waddr, i, i);
      end
      checks++;
      if (rf_data_in !== {5'(5 + i), pc, 2'(i), 32'h0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL disp_data_%0d got %h", i, rf_data_in);
      end
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (count !== 6'd3) begin errors++; $display("FAIL disp_count got %0d exp 3", count); end
  endtask

  task automatic test_cdb_priority();
    logic [31:0] d;
    @(negedge clock);
    d = $urandom;
    disp_valid = 1; disp_rd = 5'd12;
    cdb_valid = 1; cdb_tag = 5'd1; cdb_data = d;
    #1;
    checks++;
    if (rf_update_entry !== 1'b1 || rf_new_entry !== 1'b0 || rf_waddr !== 5'd1 || disp_ready !== 1'b0) begin
      errors++;
      $display("FAIL cdb_prio got upd %b new %b waddr %0d ready %b exp 1 0 1 0",
               rf_update_entry, rf_new_entry, rf_waddr, disp_ready);
    end
    checks++;
    if (rf_data_in !== {39'h0, d, 2'b10}) begin errors++; $display("FAIL cdb_data got %h", rf_data_in); end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (count !== 6'd3) begin errors++; $display("FAIL cdb_count got %0d exp 3", count); end
  endtask

  task automatic test_commit();
    @(negedge clock);
    cdb_valid = 1; cdb_tag = 5'd0; cdb_data = 32'hDEADBEEF; commit_ready = 1;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL commit_early got %b exp 0", commit_valid); end
    @(negedge clock);
    idle_inputs();
    commit_ready = 1;
    #1;
    checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL commit_head got cv %b rd %0d data %h exp 1 5 deadbeef", commit_valid, commit_rd, commit_data);
    end
    @(negedge clock);
    commit_ready = 0;
    #1;
    checks++;
    if (rf_rd_addr1 !== 5'd1 || count !== 6'd2) begin
      errors++; $display("FAIL commit_adv got head %0d count %0d exp 1 2", rf_rd_addr1, count);
    end
    checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd6) begin
      errors++; $display("FAIL commit_next got cv %b rd %0d exp 1 6", commit_valid, commit_rd);
    end
  endtask

  task automatic test_full();
    do_reset();
    dispatch_n(32);
    #1;
    checks++;
    if (count !== 6'd32 || disp_ready !== 1'b0) begin
      errors++; $display("FAIL full got count %0d ready %b exp 32 0", count, disp_ready);
    end
    @(negedge clock);
    cdb_valid = 1; cdb_tag = 5'd0; cdb_data = 32'h1234;
    #1;
    checks++; if (rf_update_entry !== 1'b1) begin errors++; $display("FAIL full_wb got %b exp 1", rf_update_entry); end
    @(negedge clock);
    idle_inputs();
    commit_ready = 1; disp_valid = 1; disp_rd = 5'd30;
    #1;
    checks++;
    if (commit_valid !== 1'b1 || disp_ready !== 1'b0) begin
      errors++; $display("FAIL full_commit got cv %b ready %b exp 1 0", commit_valid, disp_ready);
    end
    @(negedge clock);
    commit_ready = 0;
    #1;
    checks++;
    if (count !== 6'd31 || disp_ready !== 1'b1 || disp_tag !== 5'd0) begin
      errors++; $display("FAIL full_reuse got count %0d ready %b tag %0d exp 31 1 0", count, disp_ready, disp_tag);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_refill got %0d exp 32", count); end
  endtask

  task automatic test_out_of_window();
    do_reset();
    dispatch_n(3);
    cdb_valid = 1; cdb_tag = 5'd20; cdb_data = 32'hCAFE0001;
    #1;
    checks++;
    if (rf_update_entry !== 1'b0 || rf_new_entry !== 1'b0 || rf_waddr !== 5'd0 || rf_data_in !== 73'd0) begin
      errors++;
      $display("FAIL oow got upd %b new %b waddr %0d data %h exp all 0", rf_update_entry, rf_new_entry, rf_waddr, rf_data_in);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    dispatch_n(10);
    cdb_valid = 1; cdb_tag = 5'd0;
    @(negedge clock);
    idle_inputs();
    flush = 1; commit_ready = 1; disp_valid = 1; cdb_valid = 1; cdb_tag = 5'd2;
    #1;
    checks++;
    if (commit_valid !== 1'b0 || disp_ready !== 1'b0 || rf_new_entry !== 1'b0 || rf_update_entry !== 1'b0) begin
      errors++;
      $display("FAIL flush_suppress got cv %b ready %b new %b upd %b exp 0 0 0 0",
               commit_valid, disp_ready, rf_new_entry, rf_update_entry);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (count !== 6'd0 || commit_valid !== 1'b0 || disp_tag !== 5'd0) begin
      errors++; $display("FAIL flush_after got count %0d cv %b tag %0d exp 0 0 0", count, commit_valid, disp_tag);
    end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    int mhead, off, cnt;
    logic exp_ready, exp_new, exp_upd, exp_cv;
    logic [4:0] exp_tag, exp_waddr;
    logic [72:0] exp_din;
    do_reset();
    q.delete();
    mhead = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      idle_inputs();
      cnt = q.size();
      disp_valid = ($urandom_range(99) < 60);
      disp_rd = 5'($urandom); disp_pc = $urandom; disp_type = 2'($urandom);
      cdb_valid = ($urandom_range(99) < 30);
      if (cnt > 0 && $urandom_range(3) != 0) cdb_tag = 5'((mhead + $urandom_range(cnt - 1)) % 32);
      else cdb_tag = 5'($urandom);
      cdb_data = $urandom;
      flush = ($urandom_range(99) < 2);
      commit_ready = ($urandom_range(99) < 70);
      lookup_tag = 5'($urandom);
      #1;
      off = (int'(cdb_tag) - mhead + 32) % 32;
      exp_ready = (cnt < 32) && !cdb_valid && !flush;
      exp_tag = 5'((mhead + cnt) % 32);
      exp_upd = cdb_valid && !flush && (off < cnt);
      exp_new = disp_valid && exp_ready;
      exp_cv = (cnt > 0) && !flush && q[0].sv;
      exp_waddr = exp_upd ? cdb_tag : (exp_new ? exp_tag : 5'd0);
      exp_din = exp_upd ? {39'h0, cdb_data, 2'b10}
              : (exp_new ? {disp_rd, disp_pc, disp_type, 32'h0, 2'b01} : 73'd0);
      checks++;
      if (count !== 6'(cnt) || disp_tag !== exp_tag || disp_ready !== exp_ready || rf_rd_addr1 !== 5'(mhead)) begin
        errors++;
        $display("FAIL rnd_state cyc %0d got count %0d tag %0d ready %b head %0d exp %0d %0d %b %0d",
                 cyc, count, disp_tag, disp_ready, rf_rd_addr1, cnt, exp_tag, exp_ready, mhead);
      end
      checks++;
      if (rf_new_entry !== exp_new || rf_update_entry !== exp_upd || rf_waddr !== exp_waddr || rf_data_in !== exp_din) begin
        errors++;
        $display("FAIL rnd_wport cyc %0d got %b %b %0d %h exp %b %b %0d %h", cyc, rf_new_entry,
                 rf_update_entry, rf_waddr, rf_data_in, exp_new, exp_upd, exp_waddr, exp_din);
      end
      checks++;
      if (commit_valid !== exp_cv) begin
        errors++; $display("FAIL rnd_cv cyc %0d got %b exp %b", cyc, commit_valid, exp_cv);
      end
      if (exp_cv) begin
        checks++;
        if (commit_rd !== q[0].rd || commit_pc !== q[0].pc || commit_type !== q[0].typ || commit_data !== q[0].data) begin
          errors++;
          $display("FAIL rnd_commit cyc %0d got %0d %h %0d %h exp %0d %h %0d %h", cyc, commit_rd, commit_pc,
                   commit_type, commit_data, q[0].rd, q[0].pc, q[0].typ, q[0].data);
        end
      end
      checks++;
      if (lookup_data !== rf_mem[lookup_tag]) begin
        errors++; $display("FAIL rnd_lookup cyc %0d got %h exp %h", cyc, lookup_data, rf_mem[lookup_tag]);
      end
      if (flush) begin
        q.delete();
        mhead = 0;
      end else begin
        if (exp_upd) begin
          q[off].sv = 1'b1;
          q[off].data = cdb_data;
        end
        if (exp_cv && commit_ready) begin
          void'(q.pop_front());
          mhead = (mhead + 1) % 32;
        end
        if (exp_new) begin
          e.rd = disp_rd; e.pc = disp_pc; e.typ = disp_type; e.data = 32'h0; e.sv = 1'b0;
          q.push_back(e);
        end
      end
    end
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 0;
    test_reset();
    test_dispatch();
    test_cdb_priority();
    test_commit();
    test_full();
    test_out_of_window();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmpreg_ctrl.md
TMPREG_CTRL -- requirements
Module: tmpreg_ctrl

Interface
REQ-001 Parameter: ENTRIES, 32, number of temp-register entries; fixed at 32, 5-bit tags.
REQ-002 Clock and reset: one clock `clock`; reset `reset` is asynchronous and active-high.
REQ-003 `clock`  in  1  sole clock; all state updates on the rising edge.
REQ-004 `reset`  in  1  asynchronous, active-high.
REQ-005 `flush`  in  1  mispredict flush; discards all entries.
REQ-006 `disp_valid`  in  1  dispatch request.
REQ-007 `disp_ready`  out  1  dispatch accepted this cycle when high together with `disp_valid`.
REQ-008 `disp_rd`  in  5  destination register.
REQ-009 `disp_pc`  in  32  instruction PC.
REQ-010 `disp_type`  in  2  instruction type.
REQ-011 `disp_tag`  out  5  tag allocated to the dispatch, equal to the tail pointer.
REQ-012 `cdb_valid`  in  1  writeback strobe.
REQ-013 `cdb_tag`  in  5  writeback tag.
REQ-014 `cdb_data`  in  32  writeback result.
REQ-015 `commit_valid`  out  1  head entry ready to retire.
REQ-016 `commit_ready`  in  1  architectural file accepts the commit.
REQ-017 `commit_rd`  out  5  retiring destination register.
REQ-018 `commit_pc`  out  32  retiring PC.
REQ-019 `commit_type`  out  2  retiring type.
REQ-020 `commit_data`  out  32  retiring result.
REQ-021 `lookup_tag`  in  5  operand lookup tag.
REQ-022 `lookup_data`  out  73  entry contents for `lookup_tag`.
REQ-023 `count`  out  6  occupied entries, 0..32.
REQ-024 `rf_data_in`  out  73  temp-file write data.
REQ-025 `rf_waddr`  out  5  temp-file write address.
REQ-026 `rf_new_entry`  out  1  full-entry write strobe.
REQ-027 `rf_update_entry`  out  1  speculative-result write strobe.
REQ-028 `rf_rd_addr1`  out  5  read port 1 address.
REQ-029 `rf_data_out1`  in  73  read port 1 data.
REQ-030 `rf_rd_addr2`  out  5  read port 2 address.
REQ-031 `rf_data_out2`  in  73  read port 2 data.
REQ-032 Entry format: rd [72:68], PC [67:36], type [35:34], spec_data [33:2], spec_valid [1], valid [0].

Function
REQ-033 State: `head` (5 bits), `tail` (5 bits) and `count` (6 bits); pointers wrap from 31 to 0.
REQ-034 Full condition: `count` == 32.
REQ-035 Empty condition: `count` == 0.
REQ-036 `disp_ready` = !full && !`cdb_valid` && !`flush`, computed from registered `count`.
REQ-037 Dispatch accept drives, in the same cycle, `rf_new_entry`=1, `rf_waddr`=`tail`, and `rf_data_in`={`disp_rd`, `disp_pc`, `disp_type`, 32'h0, 1'b0, 1'b1}.
REQ-038 `tail` increments on the next edge after a dispatch accept.
REQ-039 A writeback with `cdb_valid`=1, `flush`=0 and `cdb_tag` inside the occupied window [head, head+count) drives `rf_update_entry`=1, `rf_waddr`=`cdb_tag`, `rf_data_in`[33:2]=`cdb_data` and `rf_data_in`[1]=1.
REQ-040 A writeback whose tag is outside the occupied window drives no strobe.
REQ-041 Write-port priority: writeback over dispatch; `rf_new_entry` and `rf_update_entry` are never high in the same cycle.
REQ-042 `rf_rd_addr1` = `head`.
REQ-043 `commit_valid` = !empty && `rf_data_out1`[0] && `rf_data_out1`[1] && !`flush`.
REQ-044 Commit fields are taken combinationally from `rf_data_out1`.
REQ-045 Commit occurs when `commit_valid` && `commit_ready`; `head` increments on the next edge.
REQ-046 A retired entry is not cleared; reuse overwrites it through `rf_new_entry`.
REQ-047 `count` next value = `count` + dispatch accept − commit; simultaneous dispatch and commit leaves `count` unchanged.
REQ-048 A writeback to `head` becomes visible to commit one cycle later (read-after-write through the register file).
REQ-049 `flush`=1 sets `head`, `tail` and `count` to 0 on the next edge and suppresses all strobes and commits in that cycle.
REQ-050 `rf_rd_addr2` = `lookup_tag`; `lookup_data` = `rf_data_out2`, passed through combinationally.
REQ-051 Undriven write fields are 0; `rf_waddr`=0 when no strobe is active.

Reset
REQ-052 Reset sets `head`, `tail` and `count` to 0 asynchronously; `disp_ready`=1, `commit_valid`=0, all strobes are 0, and `disp_tag`=0.
REQ-053 Reset mid-operation abandons in-flight entries; after reset the first dispatch receives tag 0.

Verification
REQ-054 Dispatch 3 instructions (rd=5,6,7) -> tags 0,1,2, `rf_new_entry` pulses at waddr 0,1,2, `count`=3.
REQ-055 `cdb_valid` with tag 1 and `disp_valid` high in the same cycle -> `rf_update_entry` at waddr 1, `disp_ready`=0, no new entry written.
REQ-056 Write back tag 0 with 0xDEADBEEF while `commit_ready`=1 -> `commit_valid` rises the next cycle with `commit_rd`=5 and `commit_data`=0xDEADBEEF; `head` becomes 1.
REQ-057 Fill 32 entries -> `disp_ready`=0; a commit with a dispatch in the next cycle -> tag 0 reused and `count` stays 32.
REQ-058 Writeback to tag 20 while `count`=3 -> no strobe.
REQ-059 `flush` with `count`=10 -> `count`=0 and `commit_valid`=0; the next dispatch receives tag 0.
